// File: rtl/shift_register_unit.sv
// shift_register_unit: width-parametrised shift/rotate register with serial I/O and start/busy/done handshake
module shift_register_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         func,
  input  logic               start,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               ser_in,
  output logic [WIDTH-1:0]   out,
  output logic               busy,
  output logic               done,
  output logic               ser_out
);
  localparam logic [2:0] CLEAR = 3'b000;
  localparam logic [2:0] LOAD  = 3'b001;
  localparam logic [2:0] HOLD  = 3'b010;
  localparam logic [2:0] SL    = 3'b011;
  localparam logic [2:0] SR    = 3'b100;
  localparam logic [2:0] ROL   = 3'b101;
  localparam logic [2:0] ROR   = 3'b110;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t               state_q;
  logic [2:0]           op_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]     out_q, step_d;
  logic                 busy_q, done_q, ser_q, lft_d, fill_d, sbit_d;
  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ser_out = ser_q;
  // one 1-bit step of the latched op and the bit it pushes out
  always_comb begin
    lft_d  = op_q == SL || op_q == ROL;
    fill_d = (op_q == SL || op_q == SR) ? ser_in : op_q == ROR ? out_q[0] : out_q[WIDTH-1];
    step_d = lft_d ? {out_q[WIDTH-2:0], fill_d} : {fill_d, out_q[WIDTH-1:1]};
    sbit_d = lft_d ? out_q[WIDTH-1] : out_q[0];
  end
  // control FSM: single-cycle ops finish at acceptance, shifts iterate cnt_q steps
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= CLEAR;
      cnt_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ser_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start && !busy_q) begin
            case (func)
              CLEAR: begin
                out_q  <= '0;
                done_q <= 1'b1;
              end
              LOAD: begin
                out_q  <= in;
                done_q <= 1'b1;
              end
              HOLD: done_q <= 1'b1;
              default: begin
                if (shamt == '0) begin
                  done_q <= 1'b1;
                end else begin
                  op_q    <= func;
                  cnt_q   <= shamt;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
                end
              end
            endcase
          end
        end
        SHIFT: begin
          out_q <= step_d;
          ser_q <= sbit_d;
          cnt_q <= cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_register_unit.sv
// tb_shift_register_unit: directed checks plus a done-driven scoreboard for shift_register_unit
module tb_shift_register_unit;
  logic       clk = 1'b0;
  logic       rst, start, ser_in, busy, done, ser_out;
  logic [2:0] func, shamt;
  logic [7:0] in, out;
  int         nvec = 0;
  int         nmis = 0;
  logic [8:0] sb[$];
  logic [7:0] mv = 8'h00;
  logic       ms = 1'b0;

  shift_register_unit #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk(clk), .rst(rst), .func(func), .start(start), .in(in), .shamt(shamt),
    .ser_in(ser_in), .out(out), .busy(busy), .done(done), .ser_out(ser_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // reference for one step: {bit shifted out, new value}
  function automatic logic [8:0] step1(input logic [2:0] f, input logic [7:0] v, input logic si);
    case (f)
      3'b011:  return {v[7], v[6:0], si};
      3'b100:  return {v[0], si, v[7:1]};
      3'b101:  return {v[7], v[6:0], v[7]};
      3'b110:  return {v[0], v[0], v[7:1]};
      default: return {v[0], v[7], v[7:1]};
    endcase
  endfunction

  task automatic issue(input logic [2:0] f, input logic [7:0] d, input logic [2:0] k, input logic si);
    logic [8:0] r;
    func = f; in = d; shamt = k; ser_in = si; start = 1'b1;
    if (f == 3'd0) mv = 8'h00;
    else if (f == 3'd1) mv = d;
    else if (f != 3'd2)
      for (int i = 0; i < int'(k); i++) begin
        r  = step1(f, mv, si);
        ms = r[8];
        mv = r[7:0];
      end
    sb.push_back({ms, mv});
  endtask

  task automatic run(input logic [2:0] f, input logic [7:0] d, input logic [2:0] k, input logic si, input bit poke);
    logic [7:0] v;
    logic [8:0] r;
    v = mv;
    issue(f, d, k, si);
    tick;
    start = 1'b0;
    if (f <= 3'd2 || k == 3'd0) begin
      chk8("single_out", out, mv);
      chk1("single_done", done, 1'b1);
      chk1("single_busy", busy, 1'b0);
    end else begin
      chk1("acc_busy", busy, 1'b1);
      chk1("acc_done", done, 1'b0);
      chk8("acc_out", out, v);
      for (int i = 1; i <= int'(k); i++) begin
        if (poke && i == 2) begin start = 1'b1; func = 3'd1; in = 8'hFF; end
        if (poke && i == 4) start = 1'b0;
        r = step1(f, v, si);
        v = r[7:0];
        tick;
        chk8("step_out", out, v);
        chk1("step_busy", busy, i < int'(k));
        chk1("step_done", done, i == int'(k));
      end
    end
  endtask

  always @(posedge clk) begin
    logic [8:0] e;
    #1;
    if (done === 1'b1) begin
      nvec++;
      assert (sb.size() != 0) else begin
        nmis++;
        $error("FAIL sb_unexpected_done: got done with %0d pending want >0", sb.size());
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk8("sb_out", out, e[7:0]);
        chk1("sb_ser", ser_out, e[8]);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b1; func = 3'd1; in = 8'($urandom); shamt = 3'($urandom); ser_in = 1'b1;
    tick;
    in = 8'($urandom); shamt = 3'($urandom); func = 3'($urandom);
    tick;
    chk8("rst_out", out, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_ser", ser_out, 1'b0);
    rst = 1'b0; start = 1'b0; ser_in = 1'b0;
    tick;
    chk8("idle_out", out, 8'h00);
    chk1("idle_done", done, 1'b0);
    run(3'd1, 8'hA5, 3'd0, 1'b0, 1'b0);
    chk8("load_a5", out, 8'hA5);
    tick;
    chk1("load_done_once", done, 1'b0);
    chk1("load_busy", busy, 1'b0);
    run(3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk8("clear", out, 8'h00);
    tick;
    run(3'd1, 8'hA5, 3'd0, 1'b0, 1'b0);
    tick;
    run(3'd3, 8'h00, 3'd3, 1'b0, 1'b0);
    chk8("sl3_out", out, 8'h28);
    chk1("sl3_ser", ser_out, 1'b1);
    tick;
    chk1("sl3_done_once", done, 1'b0);
    run(3'd1, 8'h94, 3'd0, 1'b0, 1'b0);
    tick;
    run(3'd7, 8'h00, 3'd2, 1'b0, 1'b0);
    chk8("asr2_out", out, 8'hE5);
    chk1("asr2_ser", ser_out, 1'b0);
    tick;
    run(3'd0, 8'h00, 3'd0, 1'b0, 1'b0);
    tick;
    run(3'd4, 8'h00, 3'd3, 1'b1, 1'b0);
    chk8("sr_fill", out, 8'hE0);
    tick;
    run(3'd1, 8'h3C, 3'd0, 1'b0, 1'b0);
    tick;
    run(3'd6, 8'h00, 3'd7, 1'b0, 1'b1);
    chk8("ror7_out", out, 8'h78);
    run(3'd5, 8'h00, 3'd1, 1'b0, 1'b0);
    chk8("rol1_b2b", out, 8'hF0);
    tick;
    chk1("rol_done_once", done, 1'b0);
    run(3'd3, 8'h00, 3'd0, 1'b1, 1'b0);
    chk8("sl0_out", out, 8'hF0);
    tick;
    chk1("sl0_busy", busy, 1'b0);
    run(3'd1, 8'h5A, 3'd0, 1'b0, 1'b0);
    tick;
    issue(3'd4, 8'h00, 3'd5, 1'b0);
    tick;
    start = 1'b0;
    tick;
    tick;
    chk8("abort_mid", out, 8'h16);
    rst = 1'b1;
    tick;
    chk8("abort_out", out, 8'h00);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk1("abort_ser", ser_out, 1'b0);
    rst = 1'b0;
    sb.delete();
    mv = 8'h00;
    ms = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk1("abort_no_done", done, 1'b0);
    end
    nvec++;
    assert (sb.size() == 0) else begin
      nmis++;
      $error("FAIL sb_pending: got %0d outstanding want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
